// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared widths, sequencer state encoding and tap-count clamp
//
// Purpose: common definitions for the FIR MAC sequencer slice.
//   ACC_W       accumulator / result width
//   PROD_W      multiplier product width
//   seq_state_t sequencer FSM encoding
//   clamp_taps  maps a requested tap count onto the legal range 1..max_taps
package filter_pkg;

  localparam int ACC_W  = 40;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  // Zero or anything above the maximum falls back to the full filter length.
  function automatic int unsigned clamp_taps(input int unsigned cfg,
                                             input int unsigned max_taps);
    if (cfg >= 1 && cfg <= max_taps) begin
      return cfg;
    end
    return max_taps;
  endfunction

endpackage

// File: rtl/filter_ctrl_delay.sv
// rtl/filter_ctrl_delay.sv - DEPTH-stage shift register for per-tap valid/first flags
//
// Purpose: delays the {valid, first} flags of each issued tap so they line up
// with the product arriving at the accumulator input.
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset, clears every stage
//   tap_valid  a tap address is issued this cycle
//   tap_first  the issued tap is tap 0
//   dly_valid  tap_valid delayed by DEPTH cycles
//   dly_first  tap_first delayed by DEPTH cycles
module filter_ctrl_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tap_valid,
  input  logic tap_first,
  output logic dly_valid,
  output logic dly_first
);

  logic [DEPTH-1:0] valid_pipe;
  logic [DEPTH-1:0] first_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_pipe <= '0;
      first_pipe <= '0;
    end else begin
      valid_pipe[0] <= tap_valid;
      first_pipe[0] <= tap_first;
      for (int k = 1; k < DEPTH; k++) begin
        valid_pipe[k] <= valid_pipe[k-1];
        first_pipe[k] <= first_pipe[k-1];
      end
    end
  end

  assign dly_valid = valid_pipe[DEPTH-1];
  assign dly_first = first_pipe[DEPTH-1];

endmodule

// File: rtl/filter_mac_sequencer.sv
// rtl/filter_mac_sequencer.sv - sequences one FIR output over the shared MAC datapath
//
// Purpose: on start, issues N coefficient/sample address pairs (one per cycle),
// drives the accumulator enable/load strobes MULT_LAT cycles later, then
// captures the accumulated sum and holds it on a valid/ready interface.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   start          request one output (accepted only in IDLE)
//   cfg_taps       tap count for the run, clamped to 1..NUM_TAPS
//   samp_base      circular-buffer index of the newest sample
//   busy           high whenever not IDLE
//   coef_addr      coefficient ROM address (tap index)
//   samp_addr      sample buffer address (samp_base - tap index, wrapping)
//   addr_valid     address pair valid this cycle
//   acc_enable     accumulator enable
//   acc_load       accumulator load (first product of the run)
//   acc_q          accumulator output
//   result         captured filter output
//   result_valid   result available
//   result_ready   consumer accepts result
module filter_mac_sequencer
  import filter_pkg::*;
#(
  parameter int NUM_TAPS = 16,
  parameter int ADDR_W   = 4,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_taps,
  input  logic [ADDR_W-1:0] samp_base,
  output logic              busy,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] samp_addr,
  output logic              addr_valid,
  output logic              acc_enable,
  output logic              acc_load,
  input  logic [ACC_W-1:0]  acc_q,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int DRAIN_W = $clog2(MULT_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(MULT_LAT);

  seq_state_t state;
  seq_state_t state_nxt;

  logic [ADDR_W-1:0]  tap_idx;
  logic [ADDR_W-1:0]  tap_last;
  logic [ADDR_W-1:0]  base_lat;
  logic [DRAIN_W-1:0] drain_cnt;

  logic [ADDR_W-1:0]  start_last;
  logic               issue_done;
  logic               drain_done;
  logic               tap_valid;
  logic               tap_first;

  // Index of the final tap for the requested count; the clamp never returns 0.
  assign start_last = ADDR_W'(clamp_taps(32'(cfg_taps), NUM_TAPS) - 1);

  assign issue_done = (state == ST_ISSUE) && (tap_idx == tap_last);
  // DRAIN spans MULT_LAT+1 cycles so the last product has been accumulated
  // and is visible on acc_q in the final DRAIN cycle.
  assign drain_done = (state == ST_DRAIN) && (drain_cnt == DRAIN_END);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)        state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_done)   state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done)   state_nxt = ST_HOLD;
      ST_HOLD:  if (result_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != ST_IDLE);
    addr_valid   = 1'b0;
    coef_addr    = '0;
    samp_addr    = '0;
    result_valid = 1'b0;
    tap_valid    = 1'b0;
    tap_first    = 1'b0;
    case (state)
      ST_ISSUE: begin
        addr_valid = 1'b1;
        coef_addr  = tap_idx;
        // Natural ADDR_W-bit wrap gives the circular-buffer walk backwards.
        samp_addr  = base_lat - tap_idx;
        tap_valid  = 1'b1;
        tap_first  = (tap_idx == '0);
      end
      ST_HOLD: begin
        result_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_idx   <= '0;
      tap_last  <= '0;
      base_lat  <= '0;
      drain_cnt <= '0;
      result    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tap_idx  <= '0;
            tap_last <= start_last;
            base_lat <= samp_base;
          end
        end
        ST_ISSUE: begin
          if (issue_done) begin
            drain_cnt <= '0;
          end else begin
            tap_idx <= tap_idx + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + DRAIN_W'(1);
          if (drain_done) begin
            result <= acc_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  filter_ctrl_delay #(
    .DEPTH(MULT_LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .tap_valid (tap_valid),
    .tap_first (tap_first),
    .dly_valid (acc_enable),
    .dly_first (acc_load)
  );

endmodule

// File: tb/tb_filter_mac_sequencer.sv
// tb/tb_filter_mac_sequencer.sv - self-checking bench for filter_mac_sequencer
module tb_filter_mac_sequencer;

  localparam int NT = 16;
  localparam int AW = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   cfg_taps;
  logic [AW-1:0] samp_base;
  logic          busy;
  logic [AW-1:0] coef_addr;
  logic [AW-1:0] samp_addr;
  logic          addr_valid;
  logic          acc_enable;
  logic          acc_load;
  logic [39:0]   acc_q;
  logic [39:0]   result;
  logic          result_valid;
  logic          result_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  filter_mac_sequencer #(
    .NUM_TAPS (NT),
    .ADDR_W   (AW),
    .MULT_LAT (ML)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_taps     (cfg_taps),
    .samp_base    (samp_base),
    .busy         (busy),
    .coef_addr    (coef_addr),
    .samp_addr    (samp_addr),
    .addr_valid   (addr_valid),
    .acc_enable   (acc_enable),
    .acc_load     (acc_load),
    .acc_q        (acc_q),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // Environment: ROM/multiplier returning prod_tab[tap] ML cycles after the
  // address, feeding a load/accumulate register with sign extension to 40 bits.
  logic signed [31:0] prod_tab [NT];
  logic signed [31:0] mpipe [ML];
  logic [39:0]        acc_model = '0;

  always_ff @(posedge clk) begin
    mpipe[0] <= addr_valid ? prod_tab[coef_addr] : 32'sd0;
    for (int k = 1; k < ML; k++) mpipe[k] <= mpipe[k-1];
    if (acc_enable) begin
      if (acc_load) acc_model <= {{8{mpipe[ML-1][31]}}, mpipe[ML-1]};
      else          acc_model <= acc_model + {{8{mpipe[ML-1][31]}}, mpipe[ML-1]};
    end
  end
  assign acc_q = acc_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete run from start to handshake. Expected timing comes from the
  // rules: start = cycle 0, tap i issued in cycle i+1, strobes ML later,
  // result_valid in cycle n+ML+2.
  task automatic do_run(input string tag, input int cfg, input int base, input int rw,
                        input int noise, input int exp_n, input int exp_last,
                        input logic [39:0] exp_res);
    int n;
    int cnt;
    int last;
    logic [4:0] exp_ctl;
    n = (cfg >= 1 && cfg <= NT) ? cfg : NT;
    cnt = 0;
    last = -1;
    cfg_taps  = cfg[AW:0];
    samp_base = base[AW-1:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= n + ML + 1; c++) begin
      exp_ctl = {1'b1, (c <= n), (c >= 1 + ML && c <= n + ML), (c == 1 + ML), 1'b0};
      chk($sformatf("%s ctl c%0d", tag, c),
          64'({busy, addr_valid, acc_enable, acc_load, result_valid}), 64'(exp_ctl));
      if (addr_valid) begin
        cnt++;
        last = int'(samp_addr);
        chk($sformatf("%s coef c%0d", tag, c), 64'(coef_addr), 64'((c - 1) & 15));
        chk($sformatf("%s samp c%0d", tag, c), 64'(samp_addr), 64'((base - (c - 1)) & 15));
      end
      start = (noise != 0 && c == 2);
      tick();
    end
    start = 1'b0;
    chk({tag, " taps"}, 64'(cnt), 64'(exp_n));
    chk({tag, " last samp"}, 64'(last), 64'(exp_last));
    for (int w = 0; w < rw; w++) begin
      chk($sformatf("%s hold rv w%0d", tag, w), 64'({busy, result_valid}), 64'(2'b11));
      chk($sformatf("%s hold res w%0d", tag, w), 64'(result), 64'(exp_res));
      start = (noise != 0);
      tick();
    end
    result_ready = 1'b1;
    start = (noise != 0);
    chk({tag, " hs rv"}, 64'(result_valid), 64'(1));
    chk({tag, " result"}, 64'(result), 64'(exp_res));
    tick();
    result_ready = 1'b0;
    start = 1'b0;
    chk({tag, " idle"}, 64'({busy, result_valid, addr_valid}), 64'(0));
  endtask

  typedef struct {
    int          cfg;
    int          base;
    int          rw;
    int          noise;
    int          exp_n;
    int          exp_last;
    logic [39:0] exp_res;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [39:0] sum;
    int rc, rb, rn;

    rst_n = 1'b0;
    start = 1'b0;
    cfg_taps = '0;
    samp_base = '0;
    result_ready = 1'b0;
    for (int k = 0; k < NT; k++) prod_tab[k] = 32'sd0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset ctl", 64'({busy, addr_valid, acc_enable, acc_load, result_valid}), 64'(0));
    chk("reset result", 64'(result), 64'(0));
    chk("reset addr", 64'({coef_addr, samp_addr}), 64'(0));

    prod_tab[0] = 32'sd10;   prod_tab[1] = -32'sd3;   prod_tab[2] = 32'sd7;     prod_tab[3] = 32'sd1;
    prod_tab[4] = 32'sd100;  prod_tab[5] = -32'sd50;  prod_tab[6] = 32'sd2000;  prod_tab[7] = -32'sd1;
    prod_tab[8] = 32'sd5;    prod_tab[9] = 32'sd6;    prod_tab[10] = 32'sd7;    prod_tab[11] = 32'sd8;
    prod_tab[12] = 32'sd9;   prod_tab[13] = 32'sd10;  prod_tab[14] = 32'sd11;   prod_tab[15] = 32'sd12;

    vecs[0] = '{cfg: 4,  base: 5,  rw: 0, noise: 0, exp_n: 4,  exp_last: 2,  exp_res: 40'd15};
    vecs[1] = '{cfg: 3,  base: 1,  rw: 1, noise: 0, exp_n: 3,  exp_last: 15, exp_res: 40'd14};
    vecs[2] = '{cfg: 0,  base: 7,  rw: 0, noise: 0, exp_n: 16, exp_last: 8,  exp_res: 40'd2132};
    vecs[3] = '{cfg: 20, base: 0,  rw: 2, noise: 0, exp_n: 16, exp_last: 1,  exp_res: 40'd2132};
    vecs[4] = '{cfg: 4,  base: 5,  rw: 5, noise: 1, exp_n: 4,  exp_last: 2,  exp_res: 40'd15};
    vecs[5] = '{cfg: 1,  base: 9,  rw: 0, noise: 1, exp_n: 1,  exp_last: 9,  exp_res: 40'd10};
    vecs[6] = '{cfg: 16, base: 15, rw: 0, noise: 0, exp_n: 16, exp_last: 0,  exp_res: 40'd2132};

    for (int v = 0; v < 7; v++) begin
      do_run($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].base, vecs[v].rw, vecs[v].noise,
             vecs[v].exp_n, vecs[v].exp_last, vecs[v].exp_res);
    end

    // Reset in the middle of ISSUE, while tap 2 is being addressed.
    cfg_taps = 5'd8;
    samp_base = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrst tap2", 64'({addr_valid, coef_addr}), 64'({1'b1, 4'd2}));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst ctl", 64'({busy, addr_valid, acc_enable, acc_load, result_valid}), 64'(0));
    chk("midrst result", 64'(result), 64'(0));
    tick();
    chk("midrst pipe", 64'({busy, acc_enable, acc_load}), 64'(0));
    do_run("after_rst", 4, 5, 0, 0, 4, 2, 40'd15);

    // Full-scale products over the maximum tap count must not truncate.
    for (int k = 0; k < NT; k++) prod_tab[k] = 32'sh7FFFFFFF;
    do_run("maxprod", 16, 0, 1, 0, 16, 1, 40'h07FFFFFFF0);

    // Random runs against the sum-of-products rule.
    for (int r = 0; r < 20; r++) begin
      rc = $urandom_range(0, 20);
      rb = $urandom_range(0, 15);
      rn = (rc >= 1 && rc <= NT) ? rc : NT;
      for (int k = 0; k < NT; k++) prod_tab[k] = $urandom;
      sum = '0;
      for (int k = 0; k < rn; k++) sum = sum + {{8{prod_tab[k][31]}}, prod_tab[k]};
      do_run($sformatf("rnd%0d", r), rc, rb, $urandom_range(0, 3), $urandom_range(0, 1),
             rn, (rb - (rn - 1)) & 15, sum);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/filter_mac_sequencer.md
Name: filter_mac_sequencer

Overview:
- Controls one FIR output computation on the shared multiply/accumulate datapath.
- On a start pulse it steps through the tap indices, issuing one coefficient address and one sample address per cycle. It drives the accumulator's enable and load strobes, aligned to the multiplier pipeline latency.
- It captures the 40-bit accumulated sum and holds it on a valid/ready result interface.
- It sits between the sample-rate control logic and the coefficient ROM, sample buffer, multiplier and filter_accumulator.

Parameters:
- NUM_TAPS, 16: maximum number of taps; also the value used when cfg_taps is out of range.
- ADDR_W, 4: coefficient and sample address width. NUM_TAPS must be no greater than 2^ADDR_W.
- MULT_LAT, 2: cycles from address issue to the product being present at the accumulator D input. Must be 1 or more.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle request to compute one output. Sampled only in IDLE.
- cfg_taps  in  ADDR_W+1  tap count for this run. Latched when start is accepted.
- samp_base  in  ADDR_W  circular-buffer index of the newest sample. Latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- coef_addr  out  ADDR_W  coefficient ROM address.
- samp_addr  out  ADDR_W  sample buffer address.
- addr_valid  out  1  high when coef_addr and samp_addr are valid this cycle.
- acc_enable  out  1  connects to the accumulator enable input.
- acc_load  out  1  connects to the accumulator load input.
- acc_q  in  40  accumulator Q output.
- result  out  40  captured filter output, signed.
- result_valid  out  1  result is available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state returns to IDLE; the tap counter, latched configuration and delay pipes clear.
  - All outputs go to 0, including result and result_valid.
  - This applies from any state, including mid-ISSUE and mid-DRAIN.
  - acc_enable must be 0 in the first cycle after reset.
- Tap count: N = cfg_taps when 1 ≤ cfg_taps ≤ NUM_TAPS. Otherwise N = NUM_TAPS.
- States: IDLE, ISSUE, DRAIN, HOLD. Encodings live in the package.
- IDLE:
  - If start is high: latch N and samp_base, set i=0, go to ISSUE.
  - Otherwise stay in IDLE. A start while not in IDLE is ignored; no queuing.
- ISSUE:
  - One tap per cycle for N cycles, with addr_valid=1.
  - coef_addr = i.
  - samp_addr = (samp_base − i) mod 2^ADDR_W, wrapping below zero (e.g. base 1, i=3 gives 14 when ADDR_W=4).
  - After the cycle with i = N−1, go to DRAIN.
- Delay pipe:
  - A MULT_LAT-deep pipe carries (valid, first) for each issued tap, with first = (i==0).
  - acc_enable = valid at the pipe output; acc_load = first at the pipe output.
  - Result: tap 0 loads the accumulator and taps 1..N−1 add to it, each MULT_LAT cycles after its address was issued.
- DRAIN:
  - Lasts MULT_LAT+1 cycles, ending one cycle after the last acc_enable, once accumulator Q includes the final product.
  - In the last DRAIN cycle, result <= acc_q; state goes to HOLD.
- HOLD:
  - result_valid=1 and result is stable.
  - On result_valid & result_ready, clear result_valid and go to IDLE.
  - A start in that same cycle is ignored; the earliest next start is accepted the following cycle.
- Latency: the start cycle is cycle 0. The first address is issued in cycle 1. result_valid rises in cycle N+MULT_LAT+2.
- acc_load and acc_enable are never high outside the MULT_LAT-cycle window after an issued tap.
- acc_q is not sampled except in the last DRAIN cycle.
- The sequencer does no arithmetic on data. Width growth from 32 to 40 bits is handled by the accumulator.

Decomposition:
- Package filter_pkg holds:
  - ACC_W=40 and PROD_W=32;
  - the sequencer state encoding;
  - the function that clamps the tap count.
- Sub-module filter_ctrl_delay holds the MULT_LAT-deep shift register for {valid, first}, parameterised by depth. It also uses the synchronous active-low rst_n.
- The FSM, tap counter, address generation and result register stay in filter_mac_sequencer.

Test Plan:
- NUM_TAPS=16, MULT_LAT=2, cfg_taps=4, samp_base=5, with the bench model of the multiplier plus filter_accumulator and products 10, −3, 7, 1:
  - samp_addr sequence is 5, 4, 3, 2;
  - acc_load is high only in cycle 3;
  - result_valid rises in cycle 8;
  - result = 15.
- cfg_taps=3, samp_base=1: samp_addr is 1, 0, 15 (wrap). coef_addr is 0, 1, 2.
- cfg_taps=0, then cfg_taps=20: each run issues exactly 16 addresses.
- start pulsed during ISSUE and during HOLD, and result_ready held low for 5 cycles:
  - no restart occurs;
  - result stays stable and result_valid stays high until ready.
  - start one cycle after the handshake is accepted.
- rst_n low for 1 cycle mid-ISSUE (i=2):
  - the next cycle has state IDLE, with busy, acc_enable and result_valid all 0;
  - a new start then runs cleanly from i=0 with acc_load on the first product.
- Products 0x7FFFFFFF × 16 taps: result = 0x07FFFFFFF0 with no truncation.
